// File: rtl/switch_debounce2_pkg.sv
// Board constants and helpers shared by the switch debounce slice.
package switch_debounce2_pkg;

  localparam int CLK_HZ      = 100_000_000;
  localparam int DEBOUNCE_MS = 10;

  localparam int DEBOUNCE_CYCLES_DEF = (CLK_HZ / 1000) * DEBOUNCE_MS;

  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: synchronizer, stability counter, IDLE/COUNT FSM and
// stable flop. accept is high in the cycle before q takes its new value.
module debounce_bit
  import switch_debounce2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic accept
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic S_IDLE  = 1'b0;
  localparam logic S_COUNT = 1'b1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_q;
  logic                   r_state;

  logic          w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_q_nxt;
  logic          w_accept;
  logic          w_sync_q;
  logic          w_diff;
  logic          w_last;

  assign w_sync_q = r_sync[SYNC_STAGES-1];
  assign w_diff   = w_sync_q != r_q;
  assign w_last   = r_cnt == CNT_MAX;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_diff) w_state_nxt = S_COUNT;
      S_COUNT: if (!w_diff || w_last) w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_q_nxt   = r_q;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_diff) w_cnt_nxt = CW'(1);
      end
      S_COUNT: begin
        if (!w_diff) begin
          w_cnt_nxt = '0;
        end else if (w_last) begin
          w_cnt_nxt = '0;
          w_q_nxt   = w_sync_q;
          w_accept  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_q    <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], d};
      r_cnt  <= w_cnt_nxt;
      r_q    <= w_q_nxt;
    end
  end

  assign q      = r_q;
  assign accept = w_accept;

endmodule

// File: rtl/switch_debounce2.sv
// Two independently debounced slide switches published as a 2-bit code
// with a one-cycle change strobe aligned to the code update.
module switch_debounce2
  import switch_debounce2_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_in,
  output logic [1:0] x_out,
  output logic       x_changed
);

  logic [1:0] w_accept;
  logic       r_changed;

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_bit0 (
    .clk   (clk),
    .rst   (rst),
    .d     (sw_in[0]),
    .q     (x_out[0]),
    .accept(w_accept[0])
  );

  debounce_bit #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES)
  ) u_bit1 (
    .clk   (clk),
    .rst   (rst),
    .d     (sw_in[1]),
    .q     (x_out[1]),
    .accept(w_accept[1])
  );

  // Registered on the same edge that updates x_out, so they stay aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_changed <= 1'b0;
    else     r_changed <= |w_accept;
  end

  assign x_changed = r_changed;

endmodule

// File: doc/switch_debounce2.md
# switch_debounce2

- Conditions two asynchronous slide-switch inputs into a clean, glitch-free 2-bit code for the downstream 2-bit decode/mux stage on the board.
- Each bit is synchronized into the `clk` domain, then debounced with its own stability counter.
- The stable code is published on `x_out`, and a one-cycle `x_changed` pulse marks every update.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000, is the number of consecutive clock edges a synchronized bit must differ from its stable value before it is accepted (10 ms at 100 MHz). Legal range is ≥ 2.
- `SYNC_STAGES`, default 2, is the synchronizer flop depth per bit. Legal range is ≥ 2.

Ports:
- `clk`, input, 1 bit: system clock, rising edge. Single clock domain.
- `rst`, input, 1 bit: asynchronous, active-high reset.
- `sw_in`, input, 2 bits: raw switch levels, asynchronous to `clk`.
- `x_out`, output, 2 bits: debounced, registered code driven to the downstream mux select.
- `x_changed`, output, 1 bit: registered pulse, high for exactly one cycle on the edge where `x_out` takes a new value.

## Operation
- Per bit `i`, the bit passes through three stages:
  - A synchronizer chain of `SYNC_STAGES` flops. Its last stage is `sync_q[i]`.
  - A counter, `cnt[i]`, of width `$clog2(DEBOUNCE_CYCLES)`.
  - A stable register, `x_out[i]`.
- Per-bit state machine, evaluated at every rising edge:
  - **IDLE** (`sync_q == x_out`, `cnt == 0`):
    - Mismatch → `cnt <= 1`, go to COUNT.
    - Otherwise hold.
  - **COUNT**:
    - Match returns (bounce) → `cnt <= 0`, go to IDLE, and `x_out` is unchanged.
    - Mismatch and `cnt == DEBOUNCE_CYCLES-1` → `x_out <= sync_q`, `cnt <= 0`, go to IDLE.
    - Otherwise `cnt <= cnt + 1`.
- The counter never wraps. Its terminal value is `DEBOUNCE_CYCLES-1`, and the counter is cleared on acceptance.
- `x_changed <= 1` on any edge where at least one bit is accepted, otherwise 0.
- If both bits are accepted on the same edge, there is one pulse and both bits update together.
- Bits are independent. A bounce on one bit never resets the other bit's counter.
- No combinational path from `sw_in` to any output.

## Timing
- Reset values (immediate on `rst` assertion, independent of `clk`):
  - All synchronizer flops are 0.
  - `cnt` is 0 and the state is IDLE.
  - `x_out` is 2'b00.
  - `x_changed` is 0.
- Reset mid-count discards all progress. After deassertion the bits start from IDLE with `x_out = 00`, and no pulse is generated on release.
- Latency:
  - Take the first edge that samples a new, held `sw_in[i]` level as edge 1.
  - `sync_q[i]` changes after edge `SYNC_STAGES`.
  - `x_out[i]` and `x_changed` update at edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
- Rejection rule: a level held for fewer than `DEBOUNCE_CYCLES` consecutive synchronized cycles is never propagated.
- Toggle cases:
  - A toggle back exactly at the acceptance edge is still accepted, because acceptance uses the `sync_q` value at that edge.
  - The following return toggle then starts a fresh count.
- `x_changed` is high for one cycle only. The earliest a second pulse can follow is `DEBOUNCE_CYCLES` cycles later for the same bit, or the next cycle when caused by the other bit.

## Structure
- Sub-module `debounce_bit` contains the synchronizer, counter, FSM and stable flop for one bit.
  - Its parameters are the same two.
  - Its outputs are `q` and a one-cycle `accept` strobe.
  - `switch_debounce2` instantiates it twice and registers `x_changed` as the OR of the two `accept` strobes.
- The shared board constants header holds `CLK_HZ` (100_000_000) and `DEBOUNCE_MS` (10). The top-level default `DEBOUNCE_CYCLES` is derived from these.
- FSM state encodings are localparams inside `debounce_bit`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=8` and `SYNC_STAGES=2`.
1. **Reset:** assert `rst` asynchronously mid-cycle with `sw_in=11` → `x_out=00` and `x_changed=0` immediately. Hold `sw_in=00` after release → no pulse for 20 cycles.
2. **Clean step:** `sw_in` 00→10, held → `x_out=10` and a single `x_changed` pulse at edge 10 (edge 1 samples the change). `x_out` stays 00 through edge 9.
3. **Bounce rejection:** `sw_in[1]` high for 5 cycles, low for 2, then high and held → no update during the bounce. `x_out=10` at edge 10 counted from the final rising sample.
4. **Simultaneous bits:** `sw_in` 00→11 in one cycle, held → `x_out` goes 00→11 in one edge (never 01 or 10) with exactly one `x_changed` pulse.
5. **Independent bits:** `sw_in[0]` rises, then `sw_in[1]` rises 3 cycles later → `x_out` goes 00→01 at edge 10, then 01→11 at edge 13, with two separate pulses.
6. **Reset mid-count:** `sw_in` 00→11, assert `rst` at edge 6, release at edge 8 with `sw_in` still 11 → `x_out=00` until 10 edges after release, then 11.
